seq_sub_64_bit: RTL and testbench
=================================

Name: seq_sub_64_bit

Overview:
Multi-cycle 64-bit subtractor with borrow in and borrow out. It is the inverse-operation companion to the team's 64-bit ripple-carry adder.
- Computes diff = a - b - bin over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, LSB slice first.
- Uses valid/ready handshakes on both input and output, so it sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 64: operand and result width. Must be an integer multiple of CHUNK.
- CHUNK, 16: bits subtracted per cycle. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a, b and bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  diff and bout are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE. Outputs: in_ready=1, out_valid=0, diff=0, bout=0. Operand registers, chunk counter and borrow register are cleared. Reset mid-operation aborts the operation silently; no result is produced.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b and bin. Clear the counter. Go to CALC.
- State CALC:
  - in_ready=0.
  - Each cycle, slice k computes a[k] - b[k] - borrow_reg, where slice k is bits [k*CHUNK +: CHUNK].
  - Write the CHUNK-bit result into diff slice k. Update borrow_reg with the slice borrow.
  - Increment k. After slice N-1 is written, go to DONE.
- State DONE:
  - out_valid=1. diff and bout (= final borrow_reg) are held stable.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
  - in_ready stays 0 in DONE. No new operand is accepted on the same edge as the result handshake.
- Latency: accept edge T; slices are written on edges T+1 through T+N; out_valid rises after edge T+N. Default is 4 cycles.
- Throughput: one operation per N+2 cycles when out_ready is held high.
- Back-pressure: out_ready=0 holds DONE indefinitely; diff and bout do not change.
- Inputs a, b and bin may change freely after acceptance; they are not sampled in CALC or DONE.
- Wrap-around: diff is modulo 2^WIDTH. bout carries the sign of the full-precision result.
- in_valid asserted in CALC or DONE: ignored. The producer must hold in_valid until it sees in_ready.
- Between operations, diff retains the last result; it is meaningful only while out_valid=1.

Optional Feature:
- Macro: SEQ_SUB_OVF_EN.
- With the macro defined:
  - Extra output port ovf, 1 bit, is added.
  - ovf = signed two's-complement overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched operands.
  - ovf is valid with out_valid and resets to 0.
- Without the macro: no ovf port and no associated logic.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - default WIDTH and CHUNK constants;
  - the derived N.
- One natural sub-module, sub_chunk: combinational CHUNK-bit subtractor with inputs x, y, bi and outputs d, bo. It is built from a ripple of full-subtractor cells. The top instantiates it once and time-multiplexes it across slices.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release → in_ready=1, out_valid=0, diff=0, bout=0. Reset asserted during CALC → IDLE next cycle, out_valid never rises.
- Mixed operands: a=0x3EBF3EBF3EBF3EBF, b=0x5555555555555555, bin=0 → diff=0xE969E969E969E96A, bout=1. out_valid rises exactly 4 cycles after acceptance.
- Borrow-in wrap: a=0, b=0, bin=1 → diff=0xFFFFFFFFFFFFFFFF, bout=1. Equal operands: a=b=0x5555555555555555, bin=0 → diff=0, bout=0.
- Back-pressure: a=0xFFFFFFFFFFFFFFFF, b=0, bin=0, with out_ready=0 for 10 cycles → diff=0xFFFFFFFFFFFFFFFF held stable, bout=0, in_ready=0 throughout. Release out_ready → in_ready=1 the following cycle.
- Back-to-back: in_valid held high with two operand sets and out_ready=1 → the second set is accepted only after the first result handshake. Each result is correct.
- SEQ_SUB_OVF_EN: a=0x8000000000000000, b=1 → diff=0x7FFFFFFFFFFFFFFF, ovf=1, bout=0. a=5, b=3 → diff=2, ovf=0.

Source files
------------

// File: rtl/seq_sub_64_bit_pkg.sv
// seq_sub_64_bit shared constants: state encodings and default geometry.
// Optional overflow output is enabled with SEQ_SUB_OVF_EN.
package seq_sub_64_bit_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;
  localparam int DEF_N     = DEF_WIDTH / DEF_CHUNK;

endpackage

// File: rtl/seq_sub_64_bit_if.sv
// seq_sub_64_bit operand/result handshake bundle.
// ovf exists only when SEQ_SUB_OVF_EN is defined.
interface seq_sub_64_bit_if
  import seq_sub_64_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SEQ_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    output a,
    output b,
    output bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
`ifdef SEQ_SUB_OVF_EN
    input  ovf,
`endif
    input  bout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
`ifdef SEQ_SUB_OVF_EN
    output ovf,
`endif
    output bout
  );

endinterface

// File: rtl/seq_sub_64_bit_sub_chunk.sv
// Combinational CHUNK-bit subtractor: ripple of full-subtractor cells.
// d = x - y - bi, bo = borrow out of the MSB cell.
module sub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[CHUNK];

endmodule

// File: rtl/seq_sub_64_bit.sv
// Multi-cycle subtractor: one CHUNK slice per cycle, LSB first.
// Define SEQ_SUB_OVF_EN to add the signed-overflow flag.
module seq_sub_64_bit
  import seq_sub_64_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_sub_64_bit_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;

  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;
  logic [CHUNK-1:0] ds;
  logic             bo;

  assign xs = a_q[cnt_q*CHUNK +: CHUNK];
  assign ys = b_q[cnt_q*CHUNK +: CHUNK];

  sub_chunk #(
    .CHUNK(CHUNK)
  ) u_sub (
    .x (xs),
    .y (ys),
    .bi(brw_q),
    .d (ds),
    .bo(bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        (state_q == CALC): begin
          diff_q[cnt_q*CHUNK +: CHUNK] <= ds;
          brw_q <= bo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
          end
        end
        (state_q == DONE): begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = brw_q;

`ifdef SEQ_SUB_OVF_EN
  // Signed overflow only possible when operand signs differ.
  assign bus.ovf = (a_q[WIDTH-1] != b_q[WIDTH-1])
                && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_seq_sub_64_bit.sv
// Directed self-checking bench for seq_sub_64_bit.
// Define SEQ_SUB_OVF_EN to also exercise the overflow flag.
module tb_seq_sub_64_bit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seq_sub_64_bit_if #(.WIDTH(64)) bus ();

  seq_sub_64_bit #(
    .WIDTH(64),
    .CHUNK(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        bin,
    output int          lat
  );
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.bin      = ~bin;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (lat >= 20) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.bin      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    tests++;
    if (bus.diff !== 64'd0) begin
      fails++;
      $display("FAIL reset_diff got %h want 0", bus.diff);
    end
    tests++;
    if (bus.bout !== 1'b0) begin
      fails++;
      $display("FAIL reset_bout got %b want 0", bus.bout);
    end
  endtask

  task automatic test_vec(
    input string       nm,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        bin,
    input logic [63:0] exp_d,
    input logic        exp_b
  );
    int lat;
    do_op(a, b, bin, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL %s_latency got %0d want 4", nm, lat);
    end
    tests++;
    if (bus.diff !== exp_d) begin
      fails++;
      $display("FAIL %s_diff got %h want %h", nm, bus.diff, exp_d);
    end
    tests++;
    if (bus.bout !== exp_b) begin
      fails++;
      $display("FAIL %s_bout got %b want %b", nm, bus.bout, exp_b);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_handshake got ov=%b ir=%b want ov=0 ir=1",
               nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    bus.out_ready = 1'b0;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL bp_latency got %0d want 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      if (bus.diff !== 64'hFFFF_FFFF_FFFF_FFFF) bad = 1;
      if (bus.bout !== 1'b0) bad = 1;
      if (bus.in_ready !== 1'b0) bad = 1;
      if (bus.out_valid !== 1'b1) bad = 1;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL bp_hold cyc %0d got d=%h bo=%b ir=%b ov=%b want d=ffffffffffffffff bo=0 ir=0 ov=1",
                 i, bus.diff, bus.bout, bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.a        = 64'h3EBF_3EBF_3EBF_3EBF;
    bus.b        = 64'h5555_5555_5555_5555;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a   = 64'd5;
    bus.b   = 64'd3;
    bus.bin = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (lat >= 20) begin
        lat = -1;
        break;
      end
    end
    tests++;
    if (lat !== 4 || bus.diff !== 64'hE969_E969_E969_E96A || bus.bout !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first got lat=%0d d=%h bo=%b want lat=4 d=e969e969e969e96a bo=1",
               lat, bus.diff, bus.bout);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_ready got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap got ir=%b ov=%b want ir=1 ov=0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_accept got ir=%b want 0", bus.in_ready);
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (lat >= 20) begin
        lat = -1;
        break;
      end
    end
    tests++;
    if (lat !== 4 || bus.diff !== 64'd1 || bus.bout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second got lat=%0d d=%h bo=%b want lat=4 d=1 bo=0",
               lat, bus.diff, bus.bout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    bus.a        = 64'h1234_5678_9ABC_DEF0;
    bus.b        = 64'h0FED_CBA9_8765_4321;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 64'd0) begin
      fails++;
      $display("FAIL midrst_state got ir=%b ov=%b d=%h want ir=1 ov=0 d=0",
               bus.in_ready, bus.out_valid, bus.diff);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midrst_no_result got out_valid=1 want 0");
    end
  endtask

`ifdef SEQ_SUB_OVF_EN
  task automatic test_ovf;
    int lat;
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
    tests++;
    if (lat !== 4 || bus.diff !== 64'h7FFF_FFFF_FFFF_FFFF
        || bus.ovf !== 1'b1 || bus.bout !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pos got lat=%0d d=%h ovf=%b bo=%b want lat=4 d=7fffffffffffffff ovf=1 bo=0",
               lat, bus.diff, bus.ovf, bus.bout);
    end
    @(negedge clk);
    do_op(64'd5, 64'd3, 1'b0, lat);
    tests++;
    if (lat !== 4 || bus.diff !== 64'd2 || bus.ovf !== 1'b0 || bus.bout !== 1'b0) begin
      fails++;
      $display("FAIL ovf_neg got lat=%0d d=%h ovf=%b bo=%b want lat=4 d=2 ovf=0 bo=0",
               lat, bus.diff, bus.ovf, bus.bout);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_vec("mixed", 64'h3EBF_3EBF_3EBF_3EBF, 64'h5555_5555_5555_5555,
             1'b0, 64'hE969_E969_E969_E96A, 1'b1);
    test_vec("wrap", 64'd0, 64'd0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    test_vec("equal", 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555,
             1'b0, 64'd0, 1'b0);
    test_vec("chain", 64'h0001_0000_0000_0000, 64'd1, 1'b0,
             64'h0000_FFFF_FFFF_FFFF, 1'b0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_SUB_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
